ones_count_accumulator: RTL and testbench

- Sequential stage directly downstream of the team's seven-input ones counter.
- Consumes one 3-bit ones-count (0..7) per accepted cycle and accumulates counts over a frame of FRAME_LEN words.
- Presents the frame total, word count and a majority flag on a valid/ready output register.
- Feeds frame-level statistics to the control/report logic.

---
 rtl/ones_count_pkg.sv | 18 +
 rtl/ones_count_accumulator_majority_cmp.sv | 31 +++
 rtl/ones_count_accumulator.sv | 141 ++++++++++++++
 tb/tb_ones_count_accumulator.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ones_count_pkg.sv
// Shared definitions for the ones-count frame statistics blocks.
package ones_count_pkg;

  // Frame accumulator states: no words held yet, or a partial frame open.
  typedef enum logic [0:0] {
    S_EMPTY = 1'b0,
    S_ACCUM = 1'b1
  } state_t;

  // Largest ones count one upstream word can carry.
  localparam int MAX_WORD_ONES = 7;

  // Width that holds the largest possible frame sum without overflow.
  function automatic int sum_width(input int frame_len);
    return $clog2(MAX_WORD_ONES * frame_len + 1);
  endfunction

endpackage

// File: rtl/ones_count_accumulator_majority_cmp.sv
// Majority test on a frame: asserted when the average ones count per word
// is strictly above half of MAX_WORD_ONES, i.e. 2*sum > 7*words.
module majority_cmp
  import ones_count_pkg::*;
#(
  parameter int SUM_W  = 6,
  parameter int WORD_W = 4
) (
  input  logic [SUM_W-1:0]  sum,
  input  logic [WORD_W-1:0] words,
  output logic              major
);

  localparam int CMP_W = SUM_W + 2;
  localparam logic [CMP_W-1:0] WORD_ONES_K = CMP_W'(MAX_WORD_ONES);

  logic [CMP_W-1:0] twice_sum_s;
  logic [CMP_W-1:0] max_ones_s;

  // Scale both sides at a width wide enough that neither product can wrap.
  always_comb begin
    twice_sum_s = {1'b0, sum, 1'b0};
    max_ones_s  = CMP_W'(words) * WORD_ONES_K;
    if (twice_sum_s > max_ones_s) begin
      major = 1'b1;
    end else begin
      major = 1'b0;
    end
  end

endmodule

// File: rtl/ones_count_accumulator.sv
// Accumulates 3-bit ones counts over a frame of FRAME_LEN accepted words and
// presents sum, word count and a majority flag on a valid/ready register.
module ones_count_accumulator
  import ones_count_pkg::*;
#(
  parameter  int FRAME_LEN = 8,
  localparam int SUM_W     = sum_width(FRAME_LEN),
  localparam int WORD_W    = $clog2(FRAME_LEN + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [2:0]        in_count,
  input  logic              flush,
  output logic              in_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [SUM_W-1:0]  out_sum,
  output logic [WORD_W-1:0] out_words,
  output logic              out_major
);

  state_t              state_r;
  state_t              state_next_s;
  logic [SUM_W-1:0]    acc_r;
  logic [WORD_W-1:0]   wcnt_r;
  logic [SUM_W-1:0]    acc_next_s;
  logic [WORD_W-1:0]   wcnt_next_s;
  logic                in_ready_s;
  logic                accept_s;
  logic                close_s;
  logic                major_next_s;
  logic                out_valid_r;
  logic [SUM_W-1:0]    out_sum_r;
  logic [WORD_W-1:0]   out_words_r;
  logic                out_major_r;

  // Handshake decode: stall only while a result is pending and not taken;
  // a frame closes on its last word or on a flush of a non-empty frame.
  always_comb begin
    in_ready_s  = !(out_valid_r && !out_ready);
    accept_s    = in_valid && in_ready_s;
    if (accept_s) begin
      acc_next_s  = acc_r + SUM_W'(in_count);
      wcnt_next_s = wcnt_r + WORD_W'(1);
    end else begin
      acc_next_s  = acc_r;
      wcnt_next_s = wcnt_r;
    end
    if (accept_s && (wcnt_next_s == WORD_W'(FRAME_LEN))) begin
      close_s = 1'b1;
    end else if (flush && in_ready_s && (wcnt_next_s != WORD_W'(0))) begin
      close_s = 1'b1;
    end else begin
      close_s = 1'b0;
    end
  end

  assign in_ready  = in_ready_s;
  assign out_valid = out_valid_r;
  assign out_sum   = out_sum_r;
  assign out_words = out_words_r;
  assign out_major = out_major_r;

  // Majority of the frame including any closing word of this cycle.
  majority_cmp #(
    .SUM_W  (SUM_W),
    .WORD_W (WORD_W)
  ) u_majority_cmp (
    .sum   (acc_next_s),
    .words (wcnt_next_s),
    .major (major_next_s)
  );

  // Next-state: open a frame on the first word unless it closes at once.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      S_EMPTY: begin
        if (accept_s && !close_s) begin
          state_next_s = S_ACCUM;
        end else begin
          state_next_s = S_EMPTY;
        end
      end
      S_ACCUM: begin
        if (close_s) begin
          state_next_s = S_EMPTY;
        end else begin
          state_next_s = S_ACCUM;
        end
      end
      default: begin
        state_next_s = S_EMPTY;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= S_EMPTY;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Running frame accumulators, cleared whenever a frame closes.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_r  <= '0;
      wcnt_r <= '0;
    end else if (close_s) begin
      acc_r  <= '0;
      wcnt_r <= '0;
    end else begin
      acc_r  <= acc_next_s;
      wcnt_r <= wcnt_next_s;
    end
  end

  // Result register: load on close, drop valid after handshake, else hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_r <= 1'b0;
      out_sum_r   <= '0;
      out_words_r <= '0;
      out_major_r <= 1'b0;
    end else if (close_s) begin
      out_valid_r <= 1'b1;
      out_sum_r   <= acc_next_s;
      out_words_r <= wcnt_next_s;
      out_major_r <= major_next_s;
    end else if (out_valid_r && out_ready) begin
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= out_valid_r;
    end
  end

endmodule

// File: tb/tb_ones_count_accumulator.sv
// Self-checking bench for ones_count_accumulator at FRAME_LEN=4.
module tb_ones_count_accumulator;

  localparam int FL = 4;
  localparam int SW = 5;
  localparam int WW = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic [2:0]    in_count = 3'd0;
  logic          flush = 1'b0;
  logic          in_ready;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [SW-1:0] out_sum;
  logic [WW-1:0] out_words;
  logic          out_major;

  int errors = 0;
  int checks = 0;

  // Behavioural model: open frame as a list of counts plus the held result.
  int   frame_q[$];
  logic m_valid = 1'b0;
  int   m_sum = 0;
  int   m_words = 0;
  logic m_major = 1'b0;
  logic m_ready = 1'b1;
  logic obs_ready;

  ones_count_accumulator #(.FRAME_LEN(FL)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_count  (in_count),
    .flush     (flush),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_words (out_words),
    .out_major (out_major)
  );

  always #5 clk = ~clk;

  // Drive one cycle of inputs, advance the model, and step past the edge.
  task automatic apply(input logic v, input logic [2:0] c, input logic f,
                       input logic r, input logic rs);
    logic acc;
    int   s;
    @(negedge clk);
    in_valid = v; in_count = c; flush = f; out_ready = r; rst = rs;
    #1;
    obs_ready = in_ready;
    m_ready = !(m_valid && !r);
    if (rs) begin
      frame_q.delete();
      m_valid = 1'b0; m_sum = 0; m_words = 0; m_major = 1'b0;
    end else begin
      acc = v && m_ready;
      if (acc) frame_q.push_back(int'(c));
      if ((acc && frame_q.size() == FL) || (f && m_ready && frame_q.size() > 0)) begin
        s = 0;
        foreach (frame_q[i]) s += frame_q[i];
        m_sum = s;
        m_words = frame_q.size();
        m_major = (2 * s > 7 * m_words);
        m_valid = 1'b1;
        frame_q.delete();
      end else if (m_valid && r) begin
        m_valid = 1'b0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    apply(1'b0, 3'd0, 1'b0, 1'b1, 1'b1);
    apply(1'b0, 3'd0, 1'b0, 1'b1, 1'b1);
    apply(1'b0, 3'd0, 1'b0, 1'b1, 1'b0);
    checks++;
    if ({out_valid, out_sum, out_words, out_major} !== {1'b0, 5'd0, 3'd0, 1'b0}) begin
      errors++;
      $display("FAIL reset_outputs: got v=%0b sum=%0d words=%0d major=%0b want 0/0/0/0",
               out_valid, out_sum, out_words, out_major);
    end
    checks++;
    if (obs_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %0b want 1", obs_ready);
    end
  endtask

  task automatic test_full_sevens;
    for (int i = 0; i < 4; i++) begin
      apply(1'b1, 3'd7, 1'b0, 1'b1, 1'b0);
      if (i == 2) begin
        checks++;
        if (out_valid !== 1'b0) begin
          errors++;
          $display("FAIL sevens_early_valid: got %0b want 0", out_valid);
        end
      end
    end
    checks++;
    if ({out_valid, out_sum, out_words, out_major} !== {1'b1, 5'd28, 3'd4, 1'b1}) begin
      errors++;
      $display("FAIL sevens_result: got v=%0b sum=%0d words=%0d major=%0b want 1/28/4/1",
               out_valid, out_sum, out_words, out_major);
    end
    apply(1'b0, 3'd0, 1'b0, 1'b1, 1'b0);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL sevens_drain: got valid=%0b want 0", out_valid);
    end
  endtask

  task automatic test_gaps;
    apply(1'b1, 3'd3, 1'b0, 1'b0, 1'b0);
    apply(1'b0, 3'd6, 1'b0, 1'b0, 1'b0);
    apply(1'b1, 3'd4, 1'b0, 1'b0, 1'b0);
    apply(1'b0, 3'd7, 1'b0, 1'b0, 1'b0);
    apply(1'b0, 3'd1, 1'b0, 1'b0, 1'b0);
    apply(1'b1, 3'd0, 1'b0, 1'b0, 1'b0);
    apply(1'b1, 3'd7, 1'b0, 1'b0, 1'b0);
    checks++;
    if ({out_valid, out_sum, out_words, out_major} !== {1'b1, 5'd14, 3'd4, 1'b0}) begin
      errors++;
      $display("FAIL gaps_tie_result: got v=%0b sum=%0d words=%0d major=%0b want 1/14/4/0",
               out_valid, out_sum, out_words, out_major);
    end
  endtask

  task automatic test_backpressure;
    for (int i = 0; i < 3; i++) begin
      apply(1'b1, 3'd2, 1'b0, 1'b0, 1'b0);
      checks++;
      if (obs_ready !== 1'b0 ||
          {out_valid, out_sum, out_words, out_major} !== {1'b1, 5'd14, 3'd4, 1'b0}) begin
        errors++;
        $display("FAIL stall_hold: got ready=%0b v=%0b sum=%0d words=%0d want ready=0 1/14/4",
                 obs_ready, out_valid, out_sum, out_words);
      end
    end
    apply(1'b1, 3'd5, 1'b0, 1'b1, 1'b0);
    checks++;
    if (obs_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL handshake_accept: got ready=%0b valid=%0b want 1/0", obs_ready, out_valid);
    end
    for (int i = 0; i < 3; i++) apply(1'b1, 3'd1, 1'b0, 1'b1, 1'b0);
    checks++;
    if ({out_valid, out_sum, out_words, out_major} !== {1'b1, 5'd8, 3'd4, 1'b0}) begin
      errors++;
      $display("FAIL next_frame: got v=%0b sum=%0d words=%0d major=%0b want 1/8/4/0",
               out_valid, out_sum, out_words, out_major);
    end
    apply(1'b0, 3'd0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_flush;
    apply(1'b1, 3'd5, 1'b0, 1'b1, 1'b0);
    apply(1'b1, 3'd2, 1'b0, 1'b1, 1'b0);
    apply(1'b0, 3'd0, 1'b1, 1'b1, 1'b0);
    checks++;
    if ({out_valid, out_sum, out_words, out_major} !== {1'b1, 5'd7, 3'd2, 1'b0}) begin
      errors++;
      $display("FAIL flush_alone: got v=%0b sum=%0d words=%0d major=%0b want 1/7/2/0",
               out_valid, out_sum, out_words, out_major);
    end
    apply(1'b0, 3'd0, 1'b0, 1'b1, 1'b0);
    apply(1'b0, 3'd0, 1'b1, 1'b1, 1'b0);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_empty: got valid=%0b want 0", out_valid);
    end
    apply(1'b1, 3'd6, 1'b0, 1'b0, 1'b0);
    apply(1'b1, 3'd6, 1'b1, 1'b0, 1'b0);
    checks++;
    if ({out_valid, out_sum, out_words, out_major} !== {1'b1, 5'd12, 3'd2, 1'b1}) begin
      errors++;
      $display("FAIL flush_with_word: got v=%0b sum=%0d words=%0d major=%0b want 1/12/2/1",
               out_valid, out_sum, out_words, out_major);
    end
    apply(1'b1, 3'd3, 1'b1, 1'b0, 1'b0);
    checks++;
    if ({out_valid, out_sum, out_words, out_major} !== {1'b1, 5'd12, 3'd2, 1'b1}) begin
      errors++;
      $display("FAIL flush_stalled: got v=%0b sum=%0d words=%0d want 1/12/2",
               out_valid, out_sum, out_words);
    end
  endtask

  task automatic test_back_to_back;
    apply(1'b1, 3'd3, 1'b1, 1'b1, 1'b0);
    checks++;
    if ({out_valid, out_sum, out_words, out_major} !== {1'b1, 5'd3, 3'd1, 1'b0}) begin
      errors++;
      $display("FAIL b2b_reload: got v=%0b sum=%0d words=%0d major=%0b want 1/3/1/0",
               out_valid, out_sum, out_words, out_major);
    end
    apply(1'b0, 3'd0, 1'b0, 1'b1, 1'b0);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_drain: got valid=%0b want 0", out_valid);
    end
  endtask

  task automatic test_reset_midframe;
    apply(1'b1, 3'd6, 1'b0, 1'b1, 1'b0);
    apply(1'b1, 3'd6, 1'b0, 1'b1, 1'b0);
    apply(1'b1, 3'd7, 1'b1, 1'b1, 1'b1);
    checks++;
    if ({out_valid, out_sum, out_words, out_major} !== {1'b0, 5'd0, 3'd0, 1'b0}) begin
      errors++;
      $display("FAIL midframe_reset: got v=%0b sum=%0d words=%0d major=%0b want 0/0/0/0",
               out_valid, out_sum, out_words, out_major);
    end
    apply(1'b0, 3'd0, 1'b1, 1'b1, 1'b0);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_discard: got valid=%0b want 0", out_valid);
    end
    for (int i = 0; i < 4; i++) apply(1'b1, 3'd1, 1'b0, 1'b0, 1'b0);
    checks++;
    if ({out_valid, out_sum, out_words, out_major} !== {1'b1, 5'd4, 3'd4, 1'b0}) begin
      errors++;
      $display("FAIL post_reset_frame: got v=%0b sum=%0d words=%0d major=%0b want 1/4/4/0",
               out_valid, out_sum, out_words, out_major);
    end
    apply(1'b0, 3'd0, 1'b0, 1'b0, 1'b1);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_pending: got valid=%0b want 0", out_valid);
    end
  endtask

  task automatic test_random;
    logic v, f, r, rs;
    logic [2:0] c;
    for (int n = 0; n < 600; n++) begin
      v  = ($urandom_range(0, 3) != 0);
      c  = 3'($urandom_range(0, 7));
      f  = ($urandom_range(0, 7) == 0);
      r  = ($urandom_range(0, 2) != 0);
      rs = ($urandom_range(0, 99) == 0);
      apply(v, c, f, r, rs);
      checks++;
      if (obs_ready !== m_ready ||
          {out_valid, out_sum, out_words, out_major} !==
          {m_valid, SW'(m_sum), WW'(m_words), m_major}) begin
        errors++;
        $display("FAIL random_cycle%0d: got ready=%0b v=%0b sum=%0d words=%0d major=%0b want ready=%0b v=%0b sum=%0d words=%0d major=%0b",
                 n, obs_ready, out_valid, out_sum, out_words, out_major,
                 m_ready, m_valid, m_sum, m_words, m_major);
      end
    end
  endtask

  initial begin
    test_reset;
    test_full_sevens;
    test_gaps;
    test_backpressure;
    test_flush;
    test_back_to_back;
    test_reset_midframe;
    test_random;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
